// File: rtl/alu_commit.sv
// alu_commit
//
// Write-back / commit stage sitting after the ALU. The control unit hands over
// one operation at a time with a valid/ready handshake. Register-type results
// are committed to accumulator A or B together with the carry and zero
// flags. Loads and stores run a request/acknowledge transaction against the
// data memory before the operation retires.
//
// Optional feature (compile-time macro COMMIT_TIMEOUT_EN):
//   When defined, a watchdog bounds each memory transaction to TIMEOUT cycles
//   of mem_req. On expiry the request is dropped, err pulses for one cycle
//   alongside done, and nothing is written.
//   When undefined, the stage waits for mem_ack indefinitely and err is tied 0.
//
// Parameters:
//   ADDR_W   data-memory address width
//   TIMEOUT  watchdog limit in cycles (only used with COMMIT_TIMEOUT_EN)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   valid      in   an operation is presented
//   ready      out  stage can accept an operation (only while idle)
//   opcode     in   6-bit opcode (def.v encoding, listed below)
//   result     in   9-bit ALU result, bit 8 is carry/borrow
//   addr       in   memory address for LDA/LDB/STA/STB
//   mem_req    out  memory request, held until mem_ack
//   mem_we     out  1 = write, 0 = read; meaningful while mem_req
//   mem_addr   out  registered memory address
//   mem_wdata  out  registered store data
//   mem_rdata  in   load data, valid with mem_ack
//   mem_ack    in   one-cycle completion strobe from memory
//   reg_a      out  accumulator A (feeds ALU in1)
//   reg_b      out  accumulator B (feeds ALU in2)
//   flag_c     out  carry flag
//   flag_z     out  zero flag
//   done       out  one-cycle pulse per retired operation
//   err        out  one-cycle pulse when a memory transaction times out

module alu_commit #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  output logic              ready,
  input  logic [5:0]        opcode,
  input  logic [8:0]        result,
  input  logic [ADDR_W-1:0] addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        reg_a,
  output logic [7:0]        reg_b,
  output logic              flag_c,
  output logic              flag_z,
  output logic              done,
  output logic              err
);

  // Opcode encoding shared with def.v. Anything not listed (NOP, jumps and
  // other flow-control codes, unused values) retires without side effects.
  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_LDCA  = 6'h01;
  localparam logic [5:0] OP_LDCB  = 6'h02;
  localparam logic [5:0] OP_ADDA  = 6'h03;
  localparam logic [5:0] OP_ADDB  = 6'h04;
  localparam logic [5:0] OP_ADDCA = 6'h05;
  localparam logic [5:0] OP_ADDCB = 6'h06;
  localparam logic [5:0] OP_SUBA  = 6'h07;
  localparam logic [5:0] OP_SUBB  = 6'h08;
  localparam logic [5:0] OP_SUBCA = 6'h09;
  localparam logic [5:0] OP_SUBCB = 6'h0A;
  localparam logic [5:0] OP_ANDA  = 6'h0B;
  localparam logic [5:0] OP_ANDB  = 6'h0C;
  localparam logic [5:0] OP_ANDCA = 6'h0D;
  localparam logic [5:0] OP_ANDCB = 6'h0E;
  localparam logic [5:0] OP_ORA   = 6'h0F;
  localparam logic [5:0] OP_ORB   = 6'h10;
  localparam logic [5:0] OP_ORCA  = 6'h11;
  localparam logic [5:0] OP_ORCB  = 6'h12;
  localparam logic [5:0] OP_ASLA  = 6'h13;
  localparam logic [5:0] OP_ASRA  = 6'h14;
  localparam logic [5:0] OP_LDA   = 6'h15;
  localparam logic [5:0] OP_LDB   = 6'h16;
  localparam logic [5:0] OP_STA   = 6'h17;
  localparam logic [5:0] OP_STB   = 6'h18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MRD  = 2'd1,
    MWR  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic accept;
  logic mem_busy;
  logic timeout_hit;

  logic dec_alu;
  logic dec_ldc;
  logic dec_load;
  logic dec_store;
  logic dec_dest_b;

  // Remembers which accumulator a pending load returns into.
  logic load_dest_b;

  assign accept   = valid & ready;
  assign mem_busy = (state == MRD) || (state == MWR);

  // Opcode decode: classify the operation and pick its target accumulator.
  // ALU ops write register, C and Z; LDC ops write register and Z but keep C.
  always_comb begin
    dec_alu    = 1'b0;
    dec_ldc    = 1'b0;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_dest_b = 1'b0;
    case (opcode)
      OP_LDCA: dec_ldc = 1'b1;
      OP_LDCB: begin
        dec_ldc    = 1'b1;
        dec_dest_b = 1'b1;
      end
      OP_ADDA, OP_ADDCA, OP_SUBA, OP_SUBCA, OP_ANDA, OP_ANDCA,
      OP_ORA, OP_ORCA, OP_ASLA, OP_ASRA: dec_alu = 1'b1;
      OP_ADDB, OP_ADDCB, OP_SUBB, OP_SUBCB, OP_ANDB, OP_ANDCB,
      OP_ORB, OP_ORCB: begin
        dec_alu    = 1'b1;
        dec_dest_b = 1'b1;
      end
      OP_LDA: dec_load = 1'b1;
      OP_LDB: begin
        dec_load   = 1'b1;
        dec_dest_b = 1'b1;
      end
      OP_STA: dec_store = 1'b1;
      OP_STB: begin
        dec_store  = 1'b1;
        dec_dest_b = 1'b1;
      end
      OP_NOP:  ;
      default: ;
    endcase
  end

  // State register. Asserting reset mid-transaction drops mem_req at once
  // because the request is decoded straight from the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Every accepted op passes through DONE so that exactly
  // one done pulse is produced per operation, including no-ops.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (dec_load) begin
            state_next = MRD;
          end else if (dec_store) begin
            state_next = MWR;
          end else begin
            state_next = DONE;
          end
        end
      end
      MRD, MWR: begin
        if (mem_ack || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode. The handshake outputs depend only on the state.
  always_comb begin
    ready   = (state == IDLE);
    mem_req = mem_busy;
    mem_we  = (state == MWR);
    done    = (state == DONE);
  end

  // Accumulators and flags. Register ops commit on the accept edge so the
  // new values are visible in the same cycle as done. Loads commit on the
  // acknowledge edge; a watchdog expiry leaves everything untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a  <= 8'h00;
      reg_b  <= 8'h00;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (accept && (dec_alu || dec_ldc)) begin
      if (dec_dest_b) begin
        reg_b <= result[7:0];
      end else begin
        reg_a <= result[7:0];
      end
      flag_z <= (result[7:0] == 8'h00);
      if (dec_alu) begin
        flag_c <= result[8];
      end
    end else if ((state == MRD) && mem_ack) begin
      if (load_dest_b) begin
        reg_b <= mem_rdata;
      end else begin
        reg_a <= mem_rdata;
      end
      flag_z <= (mem_rdata == 8'h00);
    end
  end

  // Memory-side capture: address, store data and load target are latched on
  // accept so the request stays stable even though the source moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr    <= '0;
      mem_wdata   <= 8'h00;
      load_dest_b <= 1'b0;
    end else if (accept && (dec_load || dec_store)) begin
      mem_addr    <= addr;
      load_dest_b <= dec_dest_b;
      if (dec_store) begin
        mem_wdata <= result[7:0];
      end
    end
  end

`ifdef COMMIT_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;

  // Watchdog: counts request cycles without an acknowledge. It fires in the
  // TIMEOUT-th request cycle; an acknowledge in that same cycle still wins.
  assign timeout_hit = mem_busy && !mem_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else begin
      timed_out <= timeout_hit;
      if (mem_busy && !mem_ack && !timeout_hit) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // timed_out is high exactly in the DONE cycle that follows an expiry.
  assign err = timed_out;
`else
  // No watchdog: the transaction waits for mem_ack however long it takes.
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_alu_commit.sv
// tb_alu_commit
//
// Self-checking bench for alu_commit. A behavioural model holds the expected
// accumulators and flags as a two-entry array plus two bits and applies the
// commit rules directly from the opcode meaning. A vector table drives the
// register operations, hand-written sequences cover the memory handshake
// corners, and a randomized run mixes every opcode class.

module tb_alu_commit;

  localparam int ADDR_W = 8;

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_LDCA  = 6'h01;
  localparam logic [5:0] OP_LDCB  = 6'h02;
  localparam logic [5:0] OP_ADDA  = 6'h03;
  localparam logic [5:0] OP_ADDB  = 6'h04;
  localparam logic [5:0] OP_ADDCA = 6'h05;
  localparam logic [5:0] OP_ADDCB = 6'h06;
  localparam logic [5:0] OP_SUBA  = 6'h07;
  localparam logic [5:0] OP_SUBB  = 6'h08;
  localparam logic [5:0] OP_SUBCA = 6'h09;
  localparam logic [5:0] OP_SUBCB = 6'h0A;
  localparam logic [5:0] OP_ANDA  = 6'h0B;
  localparam logic [5:0] OP_ANDB  = 6'h0C;
  localparam logic [5:0] OP_ANDCA = 6'h0D;
  localparam logic [5:0] OP_ANDCB = 6'h0E;
  localparam logic [5:0] OP_ORA   = 6'h0F;
  localparam logic [5:0] OP_ORB   = 6'h10;
  localparam logic [5:0] OP_ORCA  = 6'h11;
  localparam logic [5:0] OP_ORCB  = 6'h12;
  localparam logic [5:0] OP_ASLA  = 6'h13;
  localparam logic [5:0] OP_ASRA  = 6'h14;
  localparam logic [5:0] OP_LDA   = 6'h15;
  localparam logic [5:0] OP_LDB   = 6'h16;
  localparam logic [5:0] OP_STA   = 6'h17;
  localparam logic [5:0] OP_STB   = 6'h18;
  localparam logic [5:0] OP_JMP   = 6'h19;
  localparam logic [5:0] OP_UNDEF = 6'h3F;

  logic              clk;
  logic              rst_n;
  logic              valid;
  logic              ready;
  logic [5:0]        opcode;
  logic [8:0]        result;
  logic [ADDR_W-1:0] addr;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  logic [7:0]        reg_a;
  logic [7:0]        reg_b;
  logic              flag_c;
  logic              flag_z;
  logic              done;
  logic              err;

  alu_commit #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (valid),
    .ready     (ready),
    .opcode    (opcode),
    .result    (result),
    .addr      (addr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .reg_a     (reg_a),
    .reg_b     (reg_b),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .done      (done),
    .err       (err)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Expected architectural state: index 0 is A, index 1 is B.
  logic [7:0] m_reg [2];
  logic       m_c;
  logic       m_z;

  typedef enum int {K_ALU, K_LDC, K_LOAD, K_STORE, K_NONE} kind_e;

  typedef struct {
    logic [5:0] op;
    logic [8:0] res;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vecs [15];

  // What an opcode means architecturally.
  function automatic kind_e op_kind(input logic [5:0] op);
    case (op)
      OP_LDCA, OP_LDCB: return K_LDC;
      OP_ADDA, OP_ADDB, OP_ADDCA, OP_ADDCB, OP_SUBA, OP_SUBB, OP_SUBCA,
      OP_SUBCB, OP_ANDA, OP_ANDB, OP_ANDCA, OP_ANDCB, OP_ORA, OP_ORB,
      OP_ORCA, OP_ORCB, OP_ASLA, OP_ASRA: return K_ALU;
      OP_LDA, OP_LDB: return K_LOAD;
      OP_STA, OP_STB: return K_STORE;
      default: return K_NONE;
    endcase
  endfunction

  function automatic int op_target(input logic [5:0] op);
    case (op)
      OP_LDCB, OP_ADDB, OP_ADDCB, OP_SUBB, OP_SUBCB, OP_ANDB, OP_ANDCB,
      OP_ORB, OP_ORCB, OP_LDB: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_reg[0] = 8'h00;
    m_reg[1] = 8'h00;
    m_c      = 1'b0;
    m_z      = 1'b0;
  endtask

  task automatic model_apply(input logic [5:0] op, input logic [8:0] res,
                             input logic [7:0] rdata);
    int t;
    t = op_target(op);
    case (op_kind(op))
      K_ALU: begin
        m_reg[t] = res[7:0];
        m_c      = res[8];
        m_z      = (res[7:0] == 0);
      end
      K_LDC: begin
        m_reg[t] = res[7:0];
        m_z      = (res[7:0] == 0);
      end
      K_LOAD: begin
        m_reg[t] = rdata;
        m_z      = (rdata == 0);
      end
      default: ;
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    checkOutput({tag, " reg_a"},  reg_a,  m_reg[0]);
    checkOutput({tag, " reg_b"},  reg_b,  m_reg[1]);
    checkOutput({tag, " flag_c"}, flag_c, m_c);
    checkOutput({tag, " flag_z"}, flag_z, m_z);
  endtask

  // Runs one operation end to end from idle and checks the handshake, the
  // retire timing and the committed state against the model.
  task automatic applyStimulus(input logic [5:0] op, input logic [8:0] res,
                               input logic [7:0] adr, input int ack_delay,
                               input logic [7:0] rdata);
    kind_e k;
    k = op_kind(op);
    checkOutput("ready idle", ready, 1);
    valid  = 1'b1;
    opcode = op;
    result = res;
    addr   = adr;
    @(posedge clk); #1;
    valid  = 1'b0;
    result = ~res;
    addr   = ~adr;
    if (k == K_LOAD || k == K_STORE) begin
      checkOutput("mem_req rise", mem_req, 1);
      checkOutput("mem_we", mem_we, (k == K_STORE));
      checkOutput("mem_addr", mem_addr, adr);
      if (k == K_STORE) checkOutput("mem_wdata", mem_wdata, res[7:0]);
      checkOutput("no early done", done, 0);
      for (int i = 0; i < ack_delay; i++) begin
        @(posedge clk); #1;
        checkOutput("mem_req held", mem_req, 1);
      end
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      checkOutput("mem_req drop", mem_req, 0);
    end
    model_apply(op, res, rdata);
    checkOutput("done pulse", done, 1);
    checkOutput("err quiet", err, 0);
    checkOutput("ready in done", ready, 0);
    check_state("commit");
    @(posedge clk); #1;
    checkOutput("done single", done, 0);
    checkOutput("ready back", ready, 1);
  endtask

  logic [5:0] op_list [$];

  initial begin
    vecs[0]  = '{OP_ADDA,  9'h105, 8'h05, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{OP_SUBB,  9'h000, 8'h05, 8'h00, 1'b0, 1'b1};
    vecs[2]  = '{OP_LDCA,  9'h180, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{OP_ADDCB, 9'h100, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[4]  = '{OP_LDCB,  9'h000, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[5]  = '{OP_ANDA,  9'h00F, 8'h0F, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{OP_ORCB,  9'h1FF, 8'h0F, 8'hFF, 1'b1, 1'b0};
    vecs[7]  = '{OP_ASLA,  9'h11E, 8'h1E, 8'hFF, 1'b1, 1'b0};
    vecs[8]  = '{OP_ASRA,  9'h000, 8'h00, 8'hFF, 1'b0, 1'b1};
    vecs[9]  = '{OP_NOP,   9'h155, 8'h00, 8'hFF, 1'b0, 1'b1};
    vecs[10] = '{OP_UNDEF, 9'h012, 8'h00, 8'hFF, 1'b0, 1'b1};
    vecs[11] = '{OP_SUBCA, 9'h07E, 8'h7E, 8'hFF, 1'b0, 1'b0};
    vecs[12] = '{OP_ORA,   9'h100, 8'h00, 8'hFF, 1'b1, 1'b1};
    vecs[13] = '{OP_ANDCB, 9'h03C, 8'h00, 8'h3C, 1'b0, 1'b0};
    vecs[14] = '{OP_SUBCB, 9'h100, 8'h00, 8'h00, 1'b1, 1'b1};

    for (int i = 0; i <= 24; i++) op_list.push_back(6'(i));
    op_list.push_back(OP_JMP);
    op_list.push_back(OP_UNDEF);

    valid     = 1'b0;
    opcode    = OP_NOP;
    result    = 9'h000;
    addr      = '0;
    mem_rdata = 8'h00;
    mem_ack   = 1'b0;
    rst_n     = 1'b0;
    model_reset();

    // Reset values while reset is held.
    #12;
    checkOutput("rst ready", ready, 1);
    checkOutput("rst mem_req", mem_req, 0);
    checkOutput("rst mem_we", mem_we, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst err", err, 0);
    checkOutput("rst mem_addr", mem_addr, 0);
    checkOutput("rst mem_wdata", mem_wdata, 0);
    check_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Register-op vector table.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].op, vecs[i].res, 8'h00, 0, 8'h00);
      checkOutput($sformatf("vec%0d a", i), reg_a, vecs[i].a);
      checkOutput($sformatf("vec%0d b", i), reg_b, vecs[i].b);
      checkOutput($sformatf("vec%0d c", i), flag_c, vecs[i].c);
      checkOutput($sformatf("vec%0d z", i), flag_z, vecs[i].z);
    end

    // Load into B, acknowledge three cycles after the request rises.
    applyStimulus(OP_LDB, 9'h000, 8'h3C, 3, 8'hA7);
    checkOutput("ldb b", reg_b, 8'hA7);
    checkOutput("ldb c kept", flag_c, 1);

    // Store from the ALU result; registers must not move.
    applyStimulus(OP_STA, 9'h05A, 8'h10, 2, 8'h00);
    checkOutput("sta b kept", reg_b, 8'hA7);

    // A new op presented while a load is pending is not captured.
    valid  = 1'b1;
    opcode = OP_LDA;
    addr   = 8'h22;
    @(posedge clk); #1;
    opcode = OP_ADDB;
    result = 9'h033;
    checkOutput("busy ready low", ready, 0);
    @(posedge clk); #1;
    valid = 1'b0;
    checkOutput("busy mem_req", mem_req, 1);
    checkOutput("busy mem_we", mem_we, 0);
    mem_ack   = 1'b1;
    mem_rdata = 8'h00;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    model_apply(OP_LDA, 9'h000, 8'h00);
    checkOutput("busy done", done, 1);
    check_state("busy");
    @(posedge clk); #1;
    checkOutput("busy no extra", ready, 1);
    @(posedge clk); #1;
    checkOutput("busy no phantom done", done, 0);
    check_state("busy after");

    // An acknowledge while idle is ignored.
    mem_ack   = 1'b1;
    mem_rdata = 8'h5D;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checkOutput("idle ack done", done, 0);
    checkOutput("idle ack ready", ready, 1);
    check_state("idle ack");

    // Reset asserted in the middle of a store drops the request at once.
    valid  = 1'b1;
    opcode = OP_STB;
    result = 9'h0C3;
    addr   = 8'h44;
    @(posedge clk); #1;
    valid = 1'b0;
    checkOutput("mwr req", mem_req, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid rst mem_req", mem_req, 0);
    checkOutput("mid rst ready", ready, 1);
    model_reset();
    check_state("mid rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post rst done", done, 0);

    // Randomized mix of every opcode class against the model.
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      logic [8:0] res;
      logic [7:0] rd;
      op  = op_list[$urandom_range(0, op_list.size() - 1)];
      res = 9'($urandom);
      rd  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) res[7:0] = 8'h00;
      if ($urandom_range(0, 3) == 0) rd = 8'h00;
      applyStimulus(op, res, 8'($urandom), $urandom_range(0, 3), rd);
    end

`ifdef COMMIT_TIMEOUT_EN
    // No acknowledge: the watchdog retires the load with an error pulse.
    valid  = 1'b1;
    opcode = OP_LDA;
    addr   = 8'h77;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    checkOutput("to still waiting", mem_req, 1);
    @(posedge clk); #1;
    checkOutput("to done", done, 1);
    checkOutput("to err", err, 1);
    checkOutput("to mem_req", mem_req, 0);
    check_state("to");
    @(posedge clk); #1;
    checkOutput("to err single", err, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
